// File: rtl/switch_pkg.sv
// Shared switch types: port vectors, request/grant matrices and the
// request-tracker state encoding.
package switch_pkg;
    localparam int PORT_NUM = 4;
    localparam int CNT_W    = 6;
    localparam int DST_W    = $clog2(PORT_NUM);

    typedef logic [PORT_NUM-1:0] port_vect_t;
    typedef port_vect_t [PORT_NUM-1:0] req_mat_t;
    typedef logic [DST_W-1:0] dst_t;
    typedef dst_t [PORT_NUM-1:0] dst_vect_t;

    typedef enum logic [2:0] {
        REQ_IDLE = 3'b001,
        REQ_SEND = 3'b010,
        REQ_WAIT = 3'b100
    } req_state_t;

    function automatic logic multi_hot(input port_vect_t v);
        return (v & (v - 1'b1)) != '0;
    endfunction
endpackage

// File: rtl/voq_counter.sv
// One saturating VOQ occupancy counter; a simultaneous
// increment and decrement leave the count unchanged.
module voq_counter
    import switch_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nonzero,
    output logic empty_nxt
);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    assign full      = cnt == MAX;
    assign nonzero   = cnt != '0;
    assign empty_nxt = cnt_nxt == '0;

    always_comb begin
        cnt_nxt = cnt;
        unique case ({inc && !full, dec && nonzero})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= cnt_nxt;
    end
endmodule

// File: rtl/voq_req_tracker.sv
// VOQ occupancy tracker: counts descriptors per (input, output),
// offers a request snapshot to the arbiter and applies its grants.
module voq_req_tracker
    import switch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  port_vect_t enq_valid,
    input  dst_vect_t  enq_dst,
    output port_vect_t enq_ready,
    output logic       arb_valid_in,
    input  logic       arb_ready_in,
    output req_mat_t   rx_req_vect,
    input  logic       grt_valid,
    input  req_mat_t   grt_vect,
    output port_vect_t voq_empty,
    output logic       err_grant
);
    req_state_t state;
    req_state_t state_nxt;

    req_mat_t full;
    req_mat_t nz;
    req_mat_t empty_nxt;
    req_mat_t inc;
    req_mat_t dec;
    logic     bad_grant;
    logic     any_nz;
    logic     grant_take;

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
        for (genvar j = 0; j < PORT_NUM; j++) begin : g_out
            voq_counter #(.W(CNT_W)) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (inc[i][j]),
                .dec       (dec[i][j]),
                .full      (full[i][j]),
                .nonzero   (nz[i][j]),
                .empty_nxt (empty_nxt[i][j])
            );
        end
    end

    assign any_nz     = |nz;
    assign grant_take = grt_valid && (state == REQ_WAIT);

    always_comb begin
        enq_ready = '0;
        for (int i = 0; i < PORT_NUM; i++)
            enq_ready[i] = !full[i][enq_dst[i]];
    end

    // Grants are checked against pre-edge counts; a malformed row is
    // flagged and left untouched rather than partially applied.
    always_comb begin
        inc       = '0;
        dec       = '0;
        bad_grant = 1'b0;
        for (int i = 0; i < PORT_NUM; i++)
            for (int j = 0; j < PORT_NUM; j++)
                inc[i][j] = enq_valid[i] && enq_ready[i]
                          && (enq_dst[i] == DST_W'(j));
        if (grt_valid && !grant_take) bad_grant = 1'b1;
        if (grant_take) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                if (multi_hot(grt_vect[i])) begin
                    bad_grant = 1'b1;
                end else begin
                    for (int j = 0; j < PORT_NUM; j++) begin
                        if (grt_vect[i][j] && nz[i][j]) dec[i][j] = 1'b1;
                        if (grt_vect[i][j] && !nz[i][j]) bad_grant = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= REQ_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            REQ_IDLE: if (any_nz)       state_nxt = REQ_SEND;
            REQ_SEND: if (arb_ready_in) state_nxt = REQ_WAIT;
            REQ_WAIT: if (grt_valid)    state_nxt = REQ_IDLE;
            default:                    state_nxt = REQ_IDLE;
        endcase
    end

    always_comb begin
        arb_valid_in = state == REQ_SEND;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_req_vect <= '0;
            err_grant   <= 1'b0;
            voq_empty   <= '1;
        end else begin
            if (state == REQ_IDLE && any_nz) rx_req_vect <= nz;
            else if (grant_take)             rx_req_vect <= '0;
            err_grant <= err_grant | bad_grant;
            for (int i = 0; i < PORT_NUM; i++)
                voq_empty[i] <= &empty_nxt[i];
        end
    end
endmodule

// File: tb/tb_voq_req_tracker.sv
// Randomized scoreboard bench for voq_req_tracker against a
// count-per-VOQ reference model.
module tb_voq_req_tracker;
    import switch_pkg::*;

    localparam int MAXC = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    port_vect_t enq_valid = '0;
    dst_vect_t  enq_dst = '0;
    port_vect_t enq_ready;
    logic       arb_valid_in;
    logic       arb_ready_in = 1'b0;
    req_mat_t   rx_req_vect;
    logic       grt_valid = 1'b0;
    req_mat_t   grt_vect = '0;
    port_vect_t voq_empty;
    logic       err_grant;

    voq_req_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .enq_valid    (enq_valid),
        .enq_dst      (enq_dst),
        .enq_ready    (enq_ready),
        .arb_valid_in (arb_valid_in),
        .arb_ready_in (arb_ready_in),
        .rx_req_vect  (rx_req_vect),
        .grt_valid    (grt_valid),
        .grt_vect     (grt_vect),
        .voq_empty    (voq_empty),
        .err_grant    (err_grant)
    );

    always #5 clk = ~clk;

    // Reference model: occupancy per VOQ, phase 0 idle / 1 offered / 2 awaiting grant
    int       m_cnt [PORT_NUM][PORT_NUM];
    int       m_phase;
    bit       m_err;
    req_mat_t snap;
    req_mat_t exp_q [$];
    int       total = 0;
    int       bad = 0;

    task automatic model_reset();
        for (int i = 0; i < PORT_NUM; i++)
            for (int j = 0; j < PORT_NUM; j++) m_cnt[i][j] = 0;
        m_phase = 0;
        m_err   = 0;
        snap    = '0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int nc [PORT_NUM][PORT_NUM];
        bit anyc;
        if (!rst) begin
            model_reset();
            return;
        end
        nc   = m_cnt;
        anyc = 0;
        for (int i = 0; i < PORT_NUM; i++)
            for (int j = 0; j < PORT_NUM; j++)
                if (m_cnt[i][j] != 0) anyc = 1;
        for (int i = 0; i < PORT_NUM; i++)
            if (enq_valid[i] && m_cnt[i][int'(enq_dst[i])] < MAXC)
                nc[i][int'(enq_dst[i])]++;
        if (grt_valid) begin
            if (m_phase != 2) m_err = 1;
            else begin
                for (int i = 0; i < PORT_NUM; i++) begin
                    if ($countones(grt_vect[i]) > 1) m_err = 1;
                    else
                        for (int j = 0; j < PORT_NUM; j++)
                            if (grt_vect[i][j]) begin
                                if (m_cnt[i][j] == 0) m_err = 1;
                                else nc[i][j]--;
                            end
                end
            end
        end
        case (m_phase)
            0: if (anyc) begin
                for (int i = 0; i < PORT_NUM; i++)
                    for (int j = 0; j < PORT_NUM; j++)
                        snap[i][j] = m_cnt[i][j] != 0;
                exp_q.push_back(snap);
                m_phase = 1;
            end
            1: if (arb_ready_in) m_phase = 2;
            default: if (grt_valid) m_phase = 0;
        endcase
        m_cnt = nc;
    endtask

    task automatic step(input port_vect_t ev, input dst_vect_t d,
                        input logic ar, input logic gv, input req_mat_t gm);
        enq_valid    = ev;
        enq_dst      = d;
        arb_ready_in = ar;
        grt_valid    = gv;
        grt_vect     = gm;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic ar);
        for (int k = 0; k < n; k++) step('0, '0, ar, 1'b0, '0);
    endtask

    function automatic req_mat_t legal_grant();
        req_mat_t gm = '0;
        for (int i = 0; i < PORT_NUM; i++)
            if (snap[i] != '0) gm[i] = snap[i] & (~snap[i] + 1'b1);
        return gm;
    endfunction

    function automatic bit model_busy();
        for (int i = 0; i < PORT_NUM; i++)
            for (int j = 0; j < PORT_NUM; j++)
                if (m_cnt[i][j] != 0) return 1;
        return 0;
    endfunction

    task automatic reach_wait();
        for (int k = 0; k < 20 && m_phase != 2; k++) idle(1, 1'b1);
    endtask

    task automatic drain_all();
        for (int r = 0; r < 100 && (model_busy() || m_phase != 0); r++) begin
            reach_wait();
            if (m_phase == 2) step('0, '0, 1'b0, 1'b1, legal_grant());
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle output checks plus request scoreboard
    logic     prev_v = 1'b0;
    req_mat_t cur = '0;
    always @(negedge clk) begin
        port_vect_t er;
        port_vect_t ee;
        for (int i = 0; i < PORT_NUM; i++) begin
            er[i] = m_cnt[i][int'(enq_dst[i])] != MAXC;
            ee[i] = 1'b1;
            for (int j = 0; j < PORT_NUM; j++)
                if (m_cnt[i][j] != 0) ee[i] = 1'b0;
        end
        chk("enq_ready", 32'(enq_ready), 32'(er));
        chk("voq_empty", 32'(voq_empty), 32'(ee));
        chk("err_grant", 32'(err_grant), 32'(m_err));
        chk("arb_valid_in", 32'(arb_valid_in), 32'(m_phase == 1));
        if (arb_valid_in && !prev_v) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL req_pop got=%h expected=none", rx_req_vect);
            end else begin
                cur = exp_q.pop_front();
                if (rx_req_vect !== cur) begin
                    bad++;
                    $display("FAIL req_snap got=%h expected=%h t=%0t",
                             rx_req_vect, cur, $time);
                end
            end
        end else if (arb_valid_in) begin
            chk("req_hold", 32'(rx_req_vect), 32'(cur));
        end
        prev_v = arb_valid_in;
    end

    initial begin
        dst_vect_t d;
        req_mat_t  gm;
        port_vect_t ev;
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(3, 1'b1);

        // single request in0->dst2
        d = '0; d[0] = 2'd2;
        step(4'b0001, d, 1'b1, 1'b0, '0);
        reach_wait();
        gm = '0; gm[0] = 4'h4;
        step('0, '0, 1'b0, 1'b1, gm);
        idle(3, 1'b1);

        // held request while arbiter stalls
        d = '0; d[1] = 2'd0; d[3] = 2'd1;
        step(4'b1010, d, 1'b0, 1'b0, '0);
        step(4'b0010, d, 1'b0, 1'b0, '0);
        step(4'b0010, d, 1'b0, 1'b0, '0);
        d = '0; d[2] = 2'd3;
        step(4'b0100, d, 1'b0, 1'b0, '0);
        idle(4, 1'b0);
        drain_all();

        // fill in0->dst1 to saturation, then grant with a refused enqueue
        d = '0; d[0] = 2'd1;
        for (int k = 0; k < MAXC + 2; k++) step(4'b0001, d, 1'b0, 1'b0, '0);
        for (int k = 0; k < 20 && m_phase != 2; k++) step('0, d, 1'b1, 1'b0, '0);
        gm = '0; gm[0] = 4'h2;
        step(4'b0001, d, 1'b0, 1'b1, gm);
        step('0, d, 1'b0, 1'b0, '0);
        step(4'b0001, d, 1'b0, 1'b0, '0);
        step('0, d, 1'b0, 1'b0, '0);
        drain_all();

        // randomized traffic with legal grants
        for (int c = 0; c < 1500; c++) begin
            ev = port_vect_t'($urandom_range(0, 15));
            for (int i = 0; i < PORT_NUM; i++) d[i] = dst_t'($urandom_range(0, 3));
            gm = '0;
            if (m_phase == 2 && $urandom_range(0, 9) < 7) begin
                for (int i = 0; i < PORT_NUM; i++)
                    if (snap[i] != '0 && $urandom_range(0, 3) != 0) begin
                        int k0 = $urandom_range(0, 3);
                        bit got = 0;
                        for (int t = 0; t < PORT_NUM; t++)
                            if (!got && snap[i][(k0 + t) % PORT_NUM]) begin
                                gm[i][(k0 + t) % PORT_NUM] = 1'b1;
                                got = 1;
                            end
                    end
                step(ev, d, 1'b0, 1'b1, gm);
            end else begin
                step(ev, d, 1'($urandom_range(0, 1)), 1'b0, '0);
            end
        end
        drain_all();

        // bad grants: outside WAIT, multi-hot row, empty VOQ
        gm = '0; gm[2] = 4'h1;
        step('0, '0, 1'b0, 1'b1, gm);
        idle(2, 1'b0);
        d = '0; d[1] = 2'd0;
        step(4'b0010, d, 1'b0, 1'b0, '0);
        d[1] = 2'd1;
        step(4'b0010, d, 1'b0, 1'b0, '0);
        reach_wait();
        gm = '0; gm[1] = 4'h3; gm[0] = 4'h8;
        step('0, '0, 1'b0, 1'b1, gm);
        drain_all();

        // random traffic with arbitrary grants, error already sticky
        for (int c = 0; c < 300; c++) begin
            ev = port_vect_t'($urandom_range(0, 15));
            for (int i = 0; i < PORT_NUM; i++) d[i] = dst_t'($urandom_range(0, 3));
            gm = req_mat_t'($urandom);
            step(ev, d, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), gm);
        end

        // reset while waiting for a grant
        d = '0; d[3] = 2'd2;
        step(4'b1000, d, 1'b0, 1'b0, '0);
        reach_wait();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        idle(4, 1'b1);
        d = '0; d[2] = 2'd0;
        step(4'b0100, d, 1'b1, 1'b0, '0);
        drain_all();
        idle(3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
